// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions, flag vector type and mode encoding.
package alu_pkg;

  localparam int unsigned FLAG_W = 4;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [FLAG_W-1:0] alu_flags_t;

  // Adder operation encoding
  localparam logic ALU_MODE_ADD = 1'b0;
  localparam logic ALU_MODE_SUB = 1'b1;

endpackage : alu_pkg

// File: rtl/alu_flag_gen.sv
// Combinational NZCV flag derivation from an adder result.
// Build option ALU_BORROW_FLAG_EN: when defined, C holds a borrow on subtraction
// (inverted carry); otherwise C is the raw carry in both modes.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] result_i,
  input  logic             carry_i,
  input  logic             overflow_i,
  input  logic             mode_i,
  output alu_flags_t       flags_c
);

`ifndef ALU_BORROW_FLAG_EN
  // Mode only matters for the borrow-style carry
  logic unused_mode;
  assign unused_mode = mode_i;
`endif

  // Assemble {N,Z,C,V}
  always_comb begin
    flags_c         = '0;
    flags_c[FLAG_N] = result_i[WIDTH-1];
    flags_c[FLAG_Z] = (result_i == '0);
    flags_c[FLAG_V] = overflow_i;
`ifdef ALU_BORROW_FLAG_EN
    flags_c[FLAG_C] = (mode_i == ALU_MODE_SUB) ? ~carry_i : carry_i;
`else
    flags_c[FLAG_C] = carry_i;
`endif
  end

endmodule : alu_flag_gen

// File: rtl/alu_result_stage.sv
// Registered output stage behind the add/sub unit: small result FIFO with
// valid/ready handshake, flags captured at push, architectural flags committed
// on pop. Build option ALU_BORROW_FLAG_EN selects borrow-style C (see alu_flag_gen).
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_overflow,
  input  logic             in_mode,
  input  logic             in_set_flags,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [3:0]       flags_q
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  alu_flags_t       flags_d;

  logic [WIDTH-1:0] data_mem [DEPTH];
  alu_flags_t       flg_mem  [DEPTH];
  logic             set_mem  [DEPTH];

  alu_flags_t       in_flags_c;
  logic             push_c;
  logic             pop_c;

  // Flags are computed once on the way in and stored with the result
  alu_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .result_i   (in_result),
    .carry_i    (in_carry),
    .overflow_i (in_overflow),
    .mode_i     (in_mode),
    .flags_c    (in_flags_c)
  );

  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign out_valid  = (count_q != '0);
  assign push_c     = in_valid & in_ready;
  assign pop_c      = out_valid & out_ready;
  assign out_result = out_valid ? data_mem[rd_ptr_q] : '0;
  assign out_flags  = out_valid ? flg_mem[rd_ptr_q]  : '0;

  // Next-state for pointers, occupancy and committed flags; flush wins
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flags_d  = flags_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (set_mem[rd_ptr_q]) begin
          flags_d = flg_mem[rd_ptr_q];
        end
      end
      if (push_c && !pop_c) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_c && pop_c) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  // Entry storage, no reset needed since it is masked while empty
  always_ff @(posedge clk) begin
    if (push_c && !flush) begin
      data_mem[wr_ptr_q] <= in_result;
      flg_mem[wr_ptr_q]  <= in_flags_c;
      set_mem[wr_ptr_q]  <= in_set_flags;
    end
  end

endmodule : alu_result_stage

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage (default WIDTH/DEPTH).
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic        in_carry;
  logic        in_overflow;
  logic        in_mode;
  logic        in_set_flags;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [3:0]  out_flags;
  logic [3:0]  flags_q;

  int n_assert;
  int n_fail;

  alu_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_carry     (in_carry),
    .in_overflow  (in_overflow),
    .in_mode      (in_mode),
    .in_set_flags (in_set_flags),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .flags_q      (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] res, input logic c,
                       input logic o, input logic m, input logic s);
    in_valid     = v;
    in_result    = res;
    in_carry     = c;
    in_overflow  = o;
    in_mode      = m;
    in_set_flags = s;
  endtask

  logic [3:0] sub_flags_exp;

  initial begin
    n_assert = 0;
    n_fail   = 0;
`ifdef ALU_BORROW_FLAG_EN
    sub_flags_exp = 4'b1010;
`else
    sub_flags_exp = 4'b1000;
`endif
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_flags_q",   64'(flags_q),   64'd0);
    chk("reset_out_result", out_result,    64'd0);
    chk("reset_out_flags", 64'(out_flags), 64'd0);

    // Single add with zero result: Z and C set
    drive(1'b1, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    chk("add_out_valid", 64'(out_valid), 64'd1);
    chk("add_out_flags", 64'(out_flags), 64'h6);
    chk("add_out_result", out_result, 64'h0);
    chk("add_flags_q_before_pop", 64'(flags_q), 64'd0);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("add_flags_q_commit", 64'(flags_q), 64'h6);
    chk("add_empty", 64'(out_valid), 64'd0);

    // Sub 5-7: negative, no carry out
    out_ready = 1'b0;
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("sub_out_flags", 64'(out_flags), 64'(sub_flags_exp));
    chk("sub_out_result", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("sub_flags_q_commit", 64'(flags_q), 64'(sub_flags_exp));

    // Fill and backpressure; set_flags=0 entries must not touch flags_q
    out_ready = 1'b0;
    drive(1'b1, 64'hA1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("fill1_in_ready", 64'(in_ready), 64'd1);
    drive(1'b1, 64'hA2, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("fill2_in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 64'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("full_hold_in_ready", 64'(in_ready), 64'd0);
    chk("full_head", out_result, 64'hA1);
    out_ready = 1'b1;
    step();
    chk("release_head_a2", out_result, 64'hA2);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("release_head_a3", out_result, 64'hA3);
    chk("release_valid_a3", 64'(out_valid), 64'd1);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("fill_drained", 64'(out_valid), 64'd0);
    chk("fill_flags_q_kept", 64'(flags_q), 64'(sub_flags_exp));

    // Simultaneous push and pop at count 1; pointers wrap repeatedly
    out_ready = 1'b0;
    drive(1'b1, 64'h100, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      chk("pp_head_before", out_result, 64'h100 + 64'(i - 1));
      drive(1'b1, 64'h100 + 64'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("pp_head_after", out_result, 64'h100 + 64'(i));
      chk("pp_count_one_ready", 64'(in_ready), 64'd1);
      chk("pp_count_one_valid", 64'(out_valid), 64'd1);
    end
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("pp_drained", 64'(out_valid), 64'd0);

    // Establish flags_q = 0001 via a positive overflow result
    drive(1'b1, 64'h1, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    chk("ovf_out_flags", 64'(out_flags), 64'h1);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("ovf_flags_q", 64'(flags_q), 64'h1);

    // Flush beats pop: head with set_flags must not commit
    out_ready = 1'b0;
    drive(1'b1, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("preflush_full", 64'(in_ready), 64'd0);
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_flags_q_kept", 64'(flags_q), 64'h1);
    step();
    chk("flush_still_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stream with 2 entries queued
    out_ready = 1'b0;
    drive(1'b1, 64'hB1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("prereset_full", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_ready", 64'(in_ready), 64'd1);
    chk("async_reset_flags_q", 64'(flags_q), 64'd0);
    step();
    rst_n = 1'b1;
    drive(1'b1, 64'hC1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_reset_head", out_result, 64'hC1);
    out_ready = 1'b1;
    step();
    chk("post_reset_commit", 64'(flags_q), 64'h0);
    chk("post_reset_empty", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_alu_result_stage
